// File: rtl/mio_ram_arbiter_pkg.sv
// Shared types and constants for the two-master data-RAM arbiter.
// Latency: n/a (types only).
// Backpressure: n/a.
package mio_ram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } state_t;

    localparam int M0 = 0;
    localparam int M1 = 1;

    // Ownership state for a given master index
    function automatic state_t own_state(input logic idx);
        return idx ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/mio_ram_arbiter_if.sv
// Bundle of both master ports and the RAM macro port around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: req is held by a master until its gnt; no other stalls.
interface mio_ram_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic          m0_req;
    logic          m0_we;
    logic          m0_lock;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m0_gnt;
    logic          m0_rvalid;
    logic [DW-1:0] m0_rdata;

    logic          m1_req;
    logic          m1_we;
    logic          m1_lock;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic          m1_gnt;
    logic          m1_rvalid;
    logic [DW-1:0] m1_rdata;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output ram_we, ram_addr, ram_din,
        input  ram_dout
    );

    // Requesters and RAM macro side
    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  ram_we, ram_addr, ram_din,
        output ram_dout
    );
endinterface

// File: rtl/mio_ram_arbiter_rr_pick2.sv
// Two-way tie breaker: picks one requester, fixed M0 priority or alternating.
// Latency: combinational.
// Backpressure: none; the loser simply keeps requesting.
module rr_pick2
    import mio_ram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fixed_prio,
    output logic [1:0] win
);

    // One-hot winner; on a tie the master that did not win last time goes first
    always_comb begin
        win = 2'b00;
        if (req[M0] && !req[M1]) begin
            win[M0] = 1'b1;
        end else if (req[M1] && !req[M0]) begin
            win[M1] = 1'b1;
        end else if (req[M0] && req[M1]) begin
            if (fixed_prio || last) win[M0] = 1'b1;
            else                    win[M1] = 1'b1;
        end
    end

endmodule

// File: rtl/mio_ram_arbiter.sv
// Shares one single-port RAM between two masters with optional bounded lock.
// Latency: grant in request cycle, read data valid the following cycle.
// Backpressure: losing master holds req; a lock owner yields after MAX_HOLD grants.
module mio_ram_arbiter
    import mio_ram_arbiter_pkg::*;
#(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_HOLD   = 8
) (
    input  logic             clk,
    input  logic             RSTN,
    mio_ram_arbiter_if.slave bus
);

    localparam int            HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    state_t        state, state_nxt;
    logic          last, last_nxt;
    logic [HW-1:0] hold_cnt, hold_nxt;
    logic [1:0]    rvalid_q;

    logic [1:0]    req, we, lock, pick, win;
    logic          owned, own_idx, win_idx, win_any;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_din;

    assign req  = {bus.m1_req,  bus.m0_req};
    assign we   = {bus.m1_we,   bus.m0_we};
    assign lock = {bus.m1_lock, bus.m0_lock};

    rr_pick2 u_pick (
        .req        (req),
        .last       (last),
        .fixed_prio (FIXED_PRIO != 0),
        .win        (pick)
    );

    // Winner: lock owner keeps the RAM unless its hold budget is spent and the other waits
    always_comb begin
        win     = pick;
        owned   = (state == ST_OWN0) || (state == ST_OWN1);
        own_idx = (state == ST_OWN1);
        if (owned && req[own_idx]) begin
            if (req[~own_idx] && hold_cnt == HOLD_LAST) win = own_idx ? 2'b01 : 2'b10;
            else                                          win = own_idx ? 2'b10 : 2'b01;
        end
        if (!RSTN) win = 2'b00;
        win_any = |win;
        win_idx = win[M1];
    end

    // Next ownership state, last winner and consecutive-locked-grant count
    always_comb begin
        state_nxt = ST_IDLE;
        last_nxt  = last;
        hold_nxt  = '0;
        if (win_any) begin
            last_nxt = win_idx;
            if (lock[win_idx]) begin
                state_nxt = own_state(win_idx);
                if (owned && own_idx == win_idx)
                    hold_nxt = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;
            end
        end
    end

    // RAM port mux; idle bus drives zeros
    always_comb begin
        sel_addr = '0;
        sel_din  = '0;
        if (win_any) begin
            sel_addr = win_idx ? bus.m1_addr  : bus.m0_addr;
            sel_din  = win_idx ? bus.m1_wdata : bus.m0_wdata;
        end
    end

    assign bus.ram_we    = win_any & we[win_idx];
    assign bus.ram_addr  = sel_addr;
    assign bus.ram_din   = sel_din;
    assign bus.m0_gnt    = win[M0];
    assign bus.m1_gnt    = win[M1];
    // A read in flight when reset arrives must not surface
    assign bus.m0_rvalid = rvalid_q[M0] & RSTN;
    assign bus.m1_rvalid = rvalid_q[M1] & RSTN;
    assign bus.m0_rdata  = bus.ram_dout;
    assign bus.m1_rdata  = bus.ram_dout;

    // State registers and one-cycle read-valid pipeline
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state    <= ST_IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
            rvalid_q <= 2'b00;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
            rvalid_q <= win & ~we;
        end
    end

endmodule

// File: tb/tb_mio_ram_arbiter.sv
// Self-checking bench: vector table, hand sequences, randomized run against a reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mio_ram_arbiter;

    localparam int MAX_HOLD = 8;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mio_ram_arbiter_if #(.AW(10), .DW(32)) bus ();
    mio_ram_arbiter_if #(.AW(10), .DW(32)) fp_bus ();

    mio_ram_arbiter #(.AW(10), .DW(32), .FIXED_PRIO(0), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk), .RSTN (rstn), .bus (bus)
    );
    mio_ram_arbiter #(.AW(10), .DW(32), .FIXED_PRIO(1), .MAX_HOLD(MAX_HOLD)) dut_fp (
        .clk (clk), .RSTN (rstn), .bus (fp_bus)
    );

    // RAM macro model: write-first, one-cycle read, preload DEAD_0000 | addr
    bit   [31:0] ram_mem [1024];
    bit          ram_wr  [1024];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (bus.ram_we) begin
            ram_mem[bus.ram_addr] <= bus.ram_din;
            ram_wr[bus.ram_addr]  <= 1'b1;
            ram_q                 <= bus.ram_din;
        end else begin
            ram_q <= ram_wr[bus.ram_addr] ? ram_mem[bus.ram_addr]
                                          : (32'hDEAD_0000 | 32'(bus.ram_addr));
        end
    end
    assign bus.ram_dout    = ram_q;
    assign fp_bus.ram_dout = '0;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Reference model: owner/streak/last/pending read, plus expected memory contents
    int          m_owner, m_streak, m_last, m_pend;
    logic [31:0] m_pdata;
    bit   [31:0] m_mem [1024];
    bit          m_wr  [1024];

    function automatic logic [31:0] ram_exp(input logic [9:0] a);
        return m_wr[a] ? m_mem[a] : (32'hDEAD_0000 | 32'(a));
    endfunction

    task automatic model_step(input bit do_chk);
        logic        q[2], wv[2], lk[2];
        logic [9:0]  a[2];
        logic [31:0] d[2];
        int w, oth;
        q[0] = bus.m0_req;  wv[0] = bus.m0_we; lk[0] = bus.m0_lock; a[0] = bus.m0_addr; d[0] = bus.m0_wdata;
        q[1] = bus.m1_req;  wv[1] = bus.m1_we; lk[1] = bus.m1_lock; a[1] = bus.m1_addr; d[1] = bus.m1_wdata;
        w = -1;
        if (rstn) begin
            if (m_owner >= 0 && q[m_owner]) begin
                oth = 1 - m_owner;
                w = (q[oth] && m_streak >= MAX_HOLD) ? oth : m_owner;
            end else if (q[0] && q[1]) w = 1 - m_last;
            else if (q[0]) w = 0;
            else if (q[1]) w = 1;
        end
        if (do_chk) begin
            chk("model m0_gnt", 32'(bus.m0_gnt), 32'(w == 0));
            chk("model m1_gnt", 32'(bus.m1_gnt), 32'(w == 1));
            chk("model ram_we", 32'(bus.ram_we), 32'(w >= 0 && wv[w]));
            if (w >= 0) chk("model ram_addr", 32'(bus.ram_addr), 32'(a[w]));
            chk("model m0_rvalid", 32'(bus.m0_rvalid), 32'(rstn && m_pend == 0));
            chk("model m1_rvalid", 32'(bus.m1_rvalid), 32'(rstn && m_pend == 1));
            if (rstn && m_pend == 0) chk("model m0_rdata", bus.m0_rdata, m_pdata);
            if (rstn && m_pend == 1) chk("model m1_rdata", bus.m1_rdata, m_pdata);
        end
        if (!rstn) begin
            m_owner = -1; m_streak = 0; m_last = 1; m_pend = -1;
        end else begin
            m_pend = -1;
            if (w >= 0) begin
                if (!wv[w]) begin
                    m_pend  = w;
                    m_pdata = ram_exp(a[w]);
                end else begin
                    m_mem[a[w]] = d[w];
                    m_wr[a[w]]  = 1'b1;
                end
                if (lk[w]) begin
                    m_streak = (m_owner == w) ? m_streak + 1 : 1;
                    m_owner  = w;
                end else begin
                    m_owner = -1; m_streak = 0;
                end
                m_last = w;
            end else begin
                m_owner = -1; m_streak = 0;
            end
        end
    endtask

    task automatic drive(input logic r,
                         input logic q0, input logic w0, input logic l0,
                         input logic [9:0] a0, input logic [31:0] d0,
                         input logic q1, input logic w1, input logic l1,
                         input logic [9:0] a1, input logic [31:0] d1);
        rstn = r;
        bus.m0_req = q0; bus.m0_we = w0; bus.m0_lock = l0; bus.m0_addr = a0; bus.m0_wdata = d0;
        bus.m1_req = q1; bus.m1_we = w1; bus.m1_lock = l1; bus.m1_addr = a1; bus.m1_wdata = d1;
    endtask

    task automatic expect_g(input string nm, input logic [1:0] e_gnt, input logic [1:0] e_rv);
        chk({nm, " gnt"},    32'({bus.m1_gnt, bus.m0_gnt}),       32'(e_gnt));
        chk({nm, " rvalid"}, 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'(e_rv));
    endtask

    typedef struct {
        logic        rstn;
        logic        q0, w0, l0;
        logic [9:0]  a0;
        logic [31:0] d0;
        logic        q1, w1, l1;
        logic [9:0]  a1;
        logic [31:0] d1;
        logic [1:0]  e_gnt;
        logic        e_we;
        logic [1:0]  e_rv;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vec [10];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp_addr;
        bit          mode;

        // reset with pending requests, tie round-robin, write then read-back
        vec[0] = '{0, 1,1,0,10'd5,32'h0,   1,0,0,10'd6,32'h0,          2'b00,0,2'b00,32'h0};
        vec[1] = '{1, 1,0,0,10'd5,32'h0,   1,0,0,10'd6,32'h0,          2'b01,0,2'b00,32'h0};
        vec[2] = '{1, 1,0,0,10'd5,32'h0,   1,0,0,10'd6,32'h0,          2'b10,0,2'b01,32'hDEAD_0005};
        vec[3] = '{1, 1,0,0,10'd5,32'h0,   1,0,0,10'd6,32'h0,          2'b01,0,2'b10,32'hDEAD_0006};
        vec[4] = '{1, 1,0,0,10'd5,32'h0,   1,0,0,10'd6,32'h0,          2'b10,0,2'b01,32'hDEAD_0005};
        vec[5] = '{1, 0,0,0,10'd0,32'h0,   0,0,0,10'd0,32'h0,          2'b00,0,2'b10,32'hDEAD_0006};
        vec[6] = '{1, 0,0,0,10'd0,32'h0,   1,1,0,10'h3FF,32'h1234_5678,2'b10,1,2'b00,32'h0};
        vec[7] = '{1, 1,0,0,10'h3FF,32'h0, 0,0,0,10'd0,32'h0,          2'b01,0,2'b00,32'h0};
        vec[8] = '{1, 0,0,0,10'd0,32'h0,   0,0,0,10'd0,32'h0,          2'b00,0,2'b01,32'h1234_5678};
        vec[9] = '{1, 0,0,0,10'd0,32'h0,   0,0,0,10'd0,32'h0,          2'b00,0,2'b00,32'h0};

        fp_bus.m0_req = 0; fp_bus.m0_we = 0; fp_bus.m0_lock = 0; fp_bus.m0_addr = '0; fp_bus.m0_wdata = '0;
        fp_bus.m1_req = 0; fp_bus.m1_we = 0; fp_bus.m1_lock = 0; fp_bus.m1_addr = '0; fp_bus.m1_wdata = '0;
        drive(0, 0,0,0,0,0, 0,0,0,0,0);
        m_owner = -1; m_streak = 0; m_last = 1; m_pend = -1;

        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            drive(0, 0,0,0,0,0, 0,0,0,0,0);
            #1;
            model_step(0);
        end

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vec[i].rstn, vec[i].q0, vec[i].w0, vec[i].l0, vec[i].a0, vec[i].d0,
                  vec[i].q1, vec[i].w1, vec[i].l1, vec[i].a1, vec[i].d1);
            #1;
            chk($sformatf("row%0d gnt", i),    32'({bus.m1_gnt, bus.m0_gnt}),       32'(vec[i].e_gnt));
            chk($sformatf("row%0d ram_we", i), 32'(bus.ram_we),                     32'(vec[i].e_we));
            chk($sformatf("row%0d rvalid", i), 32'({bus.m1_rvalid, bus.m0_rvalid}), 32'(vec[i].e_rv));
            if (vec[i].e_rv[0]) chk($sformatf("row%0d m0_rdata", i), bus.m0_rdata, vec[i].e_rdata);
            if (vec[i].e_rv[1]) chk($sformatf("row%0d m1_rdata", i), bus.m1_rdata, vec[i].e_rdata);
            if (vec[i].e_gnt != 2'b00) begin
                exp_addr = vec[i].e_gnt[0] ? 32'(vec[i].a0) : 32'(vec[i].a1);
                chk($sformatf("row%0d ram_addr", i), 32'(bus.ram_addr), exp_addr);
            end
            model_step(0);
        end

        // M0 locked burst; M1 joins at cycle 2 and gets in after MAX_HOLD grants
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            drive(1, 1,0,1,10'(c),0, (c >= 2),0,0,10'h20,0);
            #1;
            expect_g($sformatf("hold c%0d", c), (c == 8) ? 2'b10 : 2'b01,
                     (c == 0) ? 2'b00 : ((c == 9) ? 2'b10 : 2'b01));
            model_step(0);
        end
        @(negedge clk);
        drive(1, 0,0,0,0,0, 0,0,0,0,0);
        #1;
        model_step(0);

        // Fixed priority instance: M0 wins every tie, M1 starves
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            fp_bus.m0_req = 1; fp_bus.m1_req = 1;
            #1;
            chk($sformatf("fixed c%0d gnt", c), 32'({fp_bus.m1_gnt, fp_bus.m0_gnt}), 32'(2'b01));
            model_step(0);
        end
        fp_bus.m0_req = 0; fp_bus.m1_req = 0;

        // Reset mid-burst: read grant, reset drops its rvalid and the lock
        @(negedge clk);
        drive(1, 1,0,1,10'd5,0, 0,0,0,0,0);
        #1; expect_g("rst burst grant", 2'b01, 2'b00); model_step(0);
        @(negedge clk);
        drive(0, 1,0,1,10'd5,0, 1,0,0,10'd6,0);
        #1; expect_g("rst burst held", 2'b00, 2'b00);
        chk("rst burst ram_we", 32'(bus.ram_we), 32'h0); model_step(0);
        @(negedge clk);
        drive(1, 1,0,0,10'd5,0, 1,0,0,10'd6,0);
        #1; expect_g("rst burst first tie", 2'b01, 2'b00); model_step(0);
        @(negedge clk);
        drive(1, 0,0,0,0,0, 1,0,1,10'd6,0);
        #1; expect_g("rst m1 lock grant", 2'b10, 2'b01); model_step(0);
        @(negedge clk);
        drive(0, 1,0,0,10'd5,0, 1,0,1,10'd6,0);
        #1; expect_g("rst m1 held", 2'b00, 2'b00); model_step(0);
        @(negedge clk);
        drive(1, 1,0,0,10'd5,0, 1,0,1,10'd6,0);
        #1; expect_g("rst m1 lock dropped", 2'b01, 2'b00); model_step(0);

        // Randomized traffic against the model
        mode = 1'b0;
        for (int c = 0; c < 800; c++) begin
            if (c % 50 == 0) mode = 1'($urandom_range(0, 1));
            @(negedge clk);
            drive(($urandom_range(0, 79) != 0),
                  ($urandom_range(0, 99) < (mode ? 95 : 55)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 99) < (mode ? 85 : 40)), 10'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 99) < (mode ? 95 : 55)), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 99) < (mode ? 85 : 40)), 10'($urandom_range(0, 7)), $urandom);
            #1;
            model_step(1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
